// File: rtl/host_trans_sequencer_pkg.sv
// Shared constants for the host transaction sequencer: PIDs, transaction
// type codes, response-status bit positions and FSM state codes.
package host_trans_sequencer_pkg;

    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_ACK   = 4'h2;

    localparam logic [1:0] TT_SETUP   = 2'd0;
    localparam logic [1:0] TT_IN      = 2'd1;
    localparam logic [1:0] TT_OUT     = 2'd2;
    localparam logic [1:0] TT_ILLEGAL = 2'd3;

    localparam int ST_DATA_SEQ = 7;
    localparam int ST_ACK      = 6;
    localparam int ST_STALL    = 5;
    localparam int ST_NAK      = 4;
    localparam int ST_TIMEOUT  = 3;
    localparam int ST_OVERFLOW = 2;
    localparam int ST_BITSTUFF = 1;
    localparam int ST_CRC      = 0;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_SEND_TOK = 4'd1;
    localparam logic [3:0] S_WAIT_TOK = 4'd2;
    localparam logic [3:0] S_SEND_DAT = 4'd3;
    localparam logic [3:0] S_WAIT_DAT = 4'd4;
    localparam logic [3:0] S_RX_EN    = 4'd5;
    localparam logic [3:0] S_RX_WAIT  = 4'd6;
    localparam logic [3:0] S_CHK      = 4'd7;
    localparam logic [3:0] S_GAP      = 4'd8;
    localparam logic [3:0] S_SEND_ACK = 4'd9;
    localparam logic [3:0] S_WAIT_ACK = 4'd10;
    localparam logic [3:0] S_DONE     = 4'd11;

    function automatic logic [3:0] token_pid(input logic [1:0] trans_type);
        case (trans_type)
            TT_SETUP: token_pid = PID_SETUP;
            TT_IN:    token_pid = PID_IN;
            default:  token_pid = PID_OUT;
        endcase
    endfunction

endpackage

// File: rtl/host_trans_sequencer_retry_gap_timer.sv
// Down-counter that holds off a retry for RETRY_GAP cycles; zero is high on
// the last gap cycle so the sequencer leaves the gap exactly on time.
module host_trans_sequencer_retry_gap_timer #(
    parameter int RETRY_GAP = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic zero
);

    localparam int W = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= W'(RETRY_GAP - 1);
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/host_trans_sequencer.sv
// Host-side USB transaction sequencer: token / DATA / ACK issue, response
// capture, retry on timeout or corruption, and one final status per transaction.
module host_trans_sequencer
    import host_trans_sequencer_pkg::*;
#(
    parameter int MAX_RETRIES = 3,
    parameter int RETRY_GAP   = 16,
    localparam int CNT_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             transReq,
    input  logic [1:0]       transType,
    input  logic             dataToggle,
    input  logic             sendPacketRdy,
    output logic             sendPacketWEn,
    output logic [3:0]       sendPacketPID,
    output logic             getPacketEn,
    input  logic             RXPacketRdy,
    input  logic [7:0]       RXPktStatus,
    output logic             transBusy,
    output logic             transDone,
    output logic [7:0]       transStatus,
    output logic             dataSeqErr,
    output logic [CNT_W-1:0] retryCnt
);

    logic [3:0]       state, next_state;
    logic [1:0]       trans_type;
    logic             toggle;
    logic [CNT_W-1:0] retry_count;
    logic [7:0]       rx_status;
    logic             wait_skip;
    logic             gap_zero;
    logic             rx_err;
    logic             send_fire;

    assign rx_err    = rx_status[ST_TIMEOUT] | rx_status[ST_CRC] | rx_status[ST_BITSTUFF];
    assign send_fire = sendPacketRdy &&
                       (state == S_SEND_TOK || state == S_SEND_DAT || state == S_SEND_ACK);

    host_trans_sequencer_retry_gap_timer #(.RETRY_GAP(RETRY_GAP)) u_gap_timer (
        .clk  (clk),
        .rst  (rst),
        .load (state == S_CHK && next_state == S_GAP),
        .en   (state == S_GAP),
        .zero (gap_zero)
    );

    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = state;
        case (state)
            S_IDLE:     if (transReq && transType != TT_ILLEGAL) next_state = S_SEND_TOK;
            S_SEND_TOK: if (sendPacketRdy) next_state = S_WAIT_TOK;
            S_WAIT_TOK: if (!wait_skip && sendPacketRdy)
                            next_state = (trans_type == TT_IN) ? S_RX_EN : S_SEND_DAT;
            S_SEND_DAT: if (sendPacketRdy) next_state = S_WAIT_DAT;
            S_WAIT_DAT: if (!wait_skip && sendPacketRdy) next_state = S_RX_EN;
            S_RX_EN:    next_state = S_RX_WAIT;
            S_RX_WAIT:  if (RXPacketRdy) next_state = S_CHK;
            S_CHK: begin
                if (rx_err)
                    next_state = (int'(retry_count) < MAX_RETRIES) ? S_GAP : S_DONE;
                else if (trans_type == TT_IN && !rx_status[ST_NAK] && !rx_status[ST_STALL])
                    next_state = S_SEND_ACK;
                else
                    next_state = S_DONE;
            end
            S_GAP:      if (gap_zero) next_state = S_SEND_TOK;
            S_SEND_ACK: if (sendPacketRdy) next_state = S_WAIT_ACK;
            S_WAIT_ACK: if (!wait_skip && sendPacketRdy) next_state = S_DONE;
            S_DONE:     next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            trans_type    <= TT_SETUP;
            toggle        <= 1'b0;
            retry_count   <= '0;
            rx_status     <= '0;
            wait_skip     <= 1'b0;
            sendPacketWEn <= 1'b0;
            sendPacketPID <= '0;
            getPacketEn   <= 1'b0;
            transBusy     <= 1'b0;
            transDone     <= 1'b0;
            transStatus   <= '0;
            dataSeqErr    <= 1'b0;
            retryCnt      <= '0;
        end else begin
            state         <= next_state;
            sendPacketWEn <= send_fire;
            // The transmitter may still report Rdy on the strobe cycle; skip it.
            wait_skip     <= send_fire;
            getPacketEn   <= (next_state == S_RX_EN);
            transDone     <= (next_state == S_DONE);
            transBusy     <= (next_state != S_IDLE);

            case (state)
                S_IDLE: if (next_state == S_SEND_TOK) begin
                    trans_type  <= transType;
                    toggle      <= dataToggle;
                    retry_count <= '0;
                end
                S_SEND_TOK: if (sendPacketRdy) sendPacketPID <= token_pid(trans_type);
                S_SEND_DAT: if (sendPacketRdy)
                    sendPacketPID <= (trans_type == TT_SETUP || !toggle) ? PID_DATA0 : PID_DATA1;
                S_SEND_ACK: if (sendPacketRdy) sendPacketPID <= PID_ACK;
                S_RX_WAIT:  if (RXPacketRdy) rx_status <= RXPktStatus;
                S_CHK:      if (next_state == S_GAP) retry_count <= retry_count + 1'b1;
                default: ;
            endcase

            if (next_state == S_DONE) begin
                transStatus <= rx_status;
                retryCnt    <= retry_count;
                dataSeqErr  <= (trans_type == TT_IN) && (rx_status[ST_DATA_SEQ] != toggle);
            end
        end
    end

endmodule

// File: tb/tb_host_trans_sequencer.sv
// Self-checking bench: transmitter/receiver models around the sequencer and a
// transaction-level reference model of retries, PID order and final status.
module tb_host_trans_sequencer;

    localparam int MAX_RETRIES = 3;
    localparam int RETRY_GAP   = 16;

    logic       clk, rst;
    logic       transReq, dataToggle, sendPacketRdy, sendPacketWEn, getPacketEn;
    logic [1:0] transType, retryCnt;
    logic [3:0] sendPacketPID;
    logic       RXPacketRdy, transBusy, transDone, dataSeqErr;
    logic [7:0] RXPktStatus, transStatus;

    host_trans_sequencer #(.MAX_RETRIES(MAX_RETRIES), .RETRY_GAP(RETRY_GAP)) dut (
        .clk(clk), .rst(rst), .transReq(transReq), .transType(transType),
        .dataToggle(dataToggle), .sendPacketRdy(sendPacketRdy),
        .sendPacketWEn(sendPacketWEn), .sendPacketPID(sendPacketPID),
        .getPacketEn(getPacketEn), .RXPacketRdy(RXPacketRdy), .RXPktStatus(RXPktStatus),
        .transBusy(transBusy), .transDone(transDone), .transStatus(transStatus),
        .dataSeqErr(dataSeqErr), .retryCnt(retryCnt)
    );

    int tests = 0, fails = 0, cyc = 0;
    int gpe_cnt = 0, done_cnt = 0, tx_hold = 0, rx_delay = 0, tx_stall_req = 0;
    bit rx_mute = 0, stray_req = 0;
    logic [3:0] sent_pids[$], exp_pids[$];
    logic [7:0] resp_q[$], plan[$];
    int tok_times[$], rx_times[$];
    int exp_attempts, exp_retry;
    logic [7:0] exp_status;
    logic exp_dse;

    initial begin clk = 0; forever #5 clk = ~clk; end
    initial forever begin @(posedge clk); cyc = cyc + 1; end
    initial begin #1000000; $display("FAIL watchdog: simulation time limit reached"); $fatal; end

    // Transmitter: busy for 1..4 cycles after each strobe, optionally stalled up front.
    initial begin
        sendPacketRdy = 1;
        forever begin
            @(negedge clk);
            if (rst) begin
                sendPacketRdy = 1; tx_hold = 0;
            end else if (sendPacketWEn) begin
                sent_pids.push_back(sendPacketPID);
                tok_times.push_back(cyc);
                sendPacketRdy = 0;
                tx_hold = $urandom_range(1, 4);
            end else if (tx_stall_req > 0) begin
                sendPacketRdy = 0; tx_hold = tx_stall_req; tx_stall_req = 0;
            end else if (tx_hold > 0) begin
                tx_hold = tx_hold - 1;
                if (tx_hold == 0) sendPacketRdy = 1;
            end
        end
    end

    // Receiver: answers each getPacketEn after 1..5 cycles with the next planned status.
    initial begin
        RXPacketRdy = 0; RXPktStatus = 0;
        forever begin
            @(negedge clk);
            RXPacketRdy = 0;
            if (rst) begin
                rx_delay = 0;
            end else if (stray_req) begin
                RXPacketRdy = 1; RXPktStatus = 8'h48; stray_req = 0;
            end else if (getPacketEn) begin
                gpe_cnt = gpe_cnt + 1;
                if (!rx_mute) rx_delay = $urandom_range(1, 5);
            end else if (rx_delay > 0) begin
                rx_delay = rx_delay - 1;
                if (rx_delay == 0) begin
                    RXPacketRdy = 1;
                    RXPktStatus = 8'h00;
                    if (resp_q.size() > 0) RXPktStatus = resp_q.pop_front();
                    rx_times.push_back(cyc);
                end
            end
        end
    end

    initial forever begin @(negedge clk); if (transDone) done_cnt = done_cnt + 1; end

    // Reference: each attempt sends token (+DATA unless IN); errors retry up to
    // MAX_RETRIES; a clean IN without NAK/stall is acknowledged.
    task automatic model(input logic [1:0] t, input logic tg);
        exp_pids.delete();
        exp_attempts = 0;
        for (int a = 0; a <= MAX_RETRIES; a++) begin
            logic [7:0] s;
            logic err;
            s = plan[a];
            exp_attempts++;
            exp_pids.push_back(t == 0 ? 4'hD : (t == 1 ? 4'h9 : 4'h1));
            if (t != 1) exp_pids.push_back((t == 0 || !tg) ? 4'h3 : 4'hB);
            exp_status = s;
            exp_retry = a;
            err = s[3] | s[1] | s[0];
            if (err && a < MAX_RETRIES) continue;
            if (!err && t == 1 && !s[4] && !s[5]) exp_pids.push_back(4'h2);
            break;
        end
        exp_dse = (t == 1) && (exp_status[7] != tg);
    endtask

    task automatic run_trans(input string name, input logic [1:0] t, input logic tg, input bit poke);
        model(t, tg);
        resp_q = plan;
        sent_pids.delete(); tok_times.delete(); rx_times.delete();
        gpe_cnt = 0; done_cnt = 0;
        @(negedge clk);
        transType = t; dataToggle = tg; transReq = 1;
        @(negedge clk);
        transReq = 0;
        tests++;
        if (transBusy !== 1'b1) begin
            fails++; $display("FAIL %s busy: got %b want 1", name, transBusy);
        end
        for (int i = 0; i < 4000 && done_cnt == 0; i++) begin
            @(negedge clk);
            transReq = (poke && i == 3);
            if (transReq) begin transType = 2'd0; dataToggle = ~tg; end
        end
        transReq = 0;
        tests++;
        if (done_cnt == 0) begin
            fails++; $display("FAIL %s timeout: no transDone within 4000 cycles", name);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (done_cnt !== 1 || transBusy !== 1'b0) begin
            fails++; $display("FAIL %s done: got %0d pulses busy=%b want 1 busy=0", name, done_cnt, transBusy);
        end
        tests++;
        if (sent_pids.size() != exp_pids.size()) begin
            fails++; $display("FAIL %s pid count: got %0d want %0d", name, sent_pids.size(), exp_pids.size());
        end else begin
            for (int i = 0; i < exp_pids.size(); i++)
                if (sent_pids[i] !== exp_pids[i]) begin
                    fails++;
                    $display("FAIL %s pid[%0d]: got %h want %h", name, i, sent_pids[i], exp_pids[i]);
                    break;
                end
        end
        tests++;
        if (gpe_cnt != exp_attempts) begin
            fails++; $display("FAIL %s getPacketEn count: got %0d want %0d", name, gpe_cnt, exp_attempts);
        end
        tests++;
        if (transStatus !== exp_status || retryCnt !== 2'(exp_retry) || dataSeqErr !== exp_dse) begin
            fails++;
            $display("FAIL %s result: got status=%h retry=%0d dse=%b want %h %0d %b",
                     name, transStatus, retryCnt, dataSeqErr, exp_status, exp_retry, exp_dse);
        end
    endtask

    task automatic set_plan(input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3);
        plan.delete();
        plan.push_back(s0); plan.push_back(s1); plan.push_back(s2); plan.push_back(s3);
    endtask

    task automatic test_reset();
        rst = 1; transReq = 0; transType = 0; dataToggle = 0;
        repeat (2) @(negedge clk);
        tests++;
        if ({sendPacketWEn, sendPacketPID, getPacketEn, transBusy, transDone,
             transStatus, dataSeqErr, retryCnt} !== 19'd0) begin
            fails++; $display("FAIL reset outputs: got nonzero, want all 0");
        end
        rst = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_directed();
        set_plan(8'h40, 0, 0, 0); run_trans("out_t1", 2'd2, 1'b1, 1'b1);
        set_plan(8'h00, 0, 0, 0); run_trans("in_ack", 2'd1, 1'b0, 1'b0);
        set_plan(8'h10, 0, 0, 0); run_trans("in_nak", 2'd1, 1'b0, 1'b0);
        set_plan(8'h00, 0, 0, 0); run_trans("in_seqerr", 2'd1, 1'b1, 1'b0);
        set_plan(8'h40, 0, 0, 0); run_trans("setup_t1", 2'd0, 1'b1, 1'b0);
        set_plan(8'h08, 8'h01, 8'h80, 0); run_trans("in_retry_ok", 2'd1, 1'b1, 1'b0);
    endtask

    task automatic test_retry_exhaust();
        set_plan(8'h08, 8'h08, 8'h08, 8'h08);
        run_trans("in_retry_max", 2'd1, 1'b0, 1'b0);
        // rx pulse -> CHK -> RETRY_GAP idle cycles -> SEND_TOK -> registered strobe
        for (int i = 0; i < MAX_RETRIES; i++) begin
            tests++;
            if (tok_times.size() <= i + 1 || rx_times.size() <= i) begin
                fails++; $display("FAIL retry gap %0d: missing attempt", i);
            end else if (tok_times[i+1] - rx_times[i] != RETRY_GAP + 3) begin
                fails++;
                $display("FAIL retry gap %0d: got %0d want %0d", i, tok_times[i+1] - rx_times[i], RETRY_GAP + 3);
            end
        end
    endtask

    task automatic test_ignored_inputs();
        sent_pids.delete(); done_cnt = 0;
        @(negedge clk); transType = 2'd3; transReq = 1;
        @(negedge clk); transReq = 0;
        repeat (8) @(negedge clk);
        tests++;
        if (transBusy !== 1'b0 || sent_pids.size() != 0) begin
            fails++; $display("FAIL illegal type: got busy=%b pids=%0d want 0 0", transBusy, sent_pids.size());
        end
        stray_req = 1;
        repeat (6) @(negedge clk);
        tests++;
        if (done_cnt != 0 || transBusy !== 1'b0) begin
            fails++; $display("FAIL stray rx: got done=%0d busy=%b want 0 0", done_cnt, transBusy);
        end
    endtask

    task automatic test_reset_mid();
        rx_mute = 1; gpe_cnt = 0; done_cnt = 0;
        @(negedge clk); transType = 2'd1; dataToggle = 0; transReq = 1;
        @(negedge clk); transReq = 0;
        for (int i = 0; i < 200 && gpe_cnt == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        tests++;
        if (gpe_cnt != 1 || transBusy !== 1'b1) begin
            fails++; $display("FAIL reset_mid setup: got gpe=%0d busy=%b want 1 1", gpe_cnt, transBusy);
        end
        rst = 1;
        #1;
        tests++;
        if ({sendPacketWEn, sendPacketPID, getPacketEn, transBusy, transDone,
             transStatus, dataSeqErr, retryCnt} !== 19'd0) begin
            fails++; $display("FAIL reset_mid outputs: got nonzero, want all 0");
        end
        @(negedge clk); rst = 0; rx_mute = 0;
        repeat (6) @(negedge clk);
        tests++;
        if (done_cnt != 0 || transBusy !== 1'b0) begin
            fails++; $display("FAIL reset_mid after: got done=%0d busy=%b want 0 0", done_cnt, transBusy);
        end
        set_plan(8'h40, 0, 0, 0); run_trans("after_reset", 2'd2, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            logic [1:0] t;
            logic tg;
            plan.delete();
            for (int a = 0; a <= MAX_RETRIES; a++) begin
                logic [7:0] s;
                s = 8'($urandom);
                s[3] = ($urandom_range(0, 3) == 0);
                s[1] = ($urandom_range(0, 5) == 0);
                s[0] = ($urandom_range(0, 5) == 0);
                s[4] = ($urandom_range(0, 4) == 0);
                s[5] = ($urandom_range(0, 6) == 0);
                plan.push_back(s);
            end
            t = 2'($urandom_range(0, 2));
            tg = 1'($urandom);
            tx_stall_req = $urandom_range(0, 6);
            run_trans($sformatf("rand%0d", n), t, tg, 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_retry_exhaust();
        test_ignored_inputs();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
